dct_zigzag_serializer: RTL and testbench
========================================

Name: dct_zigzag_serializer

Overview:
- Downstream consumer of the 2D DCT top level. Collects the DIM result vectors of one block (one vector per valid_in cycle) into a DIM x DIM coefficient store.
- Drains the block as a serial coefficient stream in zigzag order over a valid/ready handshake.
- Feeds the entropy-coding stage of the compression peripheral and flags any dropped vectors.

Parameters:
- WIDTH, 16, signed coefficient width (matches DCT output width)
- DIM, 8, block dimension; zigzag table generated at elaboration for DIM x DIM; only DIM=8 is verified
- IDX_WIDTH, $clog2(DIM*DIM), coefficient index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- valid_in  in  1  in_vec carries the next result vector of the current block
- in_vec  in  WIDTH x DIM  signed result vector; element e of vector v is C[v][e]
- in_ready  out  1  store can accept a vector this cycle
- coef_out  out  WIDTH  signed coefficient in zigzag order
- coef_idx  out  IDX_WIDTH  zigzag position 0..DIM*DIM-1 of coef_out
- coef_valid  out  1  coef_out/coef_idx valid
- coef_ready  in  1  downstream accepts coefficient
- coef_last  out  1  coef_out is position DIM*DIM-1 of the block
- overflow  out  1  sticky: a vector was dropped

Behaviour:
- Single clock. All state updates on posedge clk. Reset is synchronous, active-low: rst==0 at an edge is applied at that edge.
- Reset values:
  - in_ready=1; coef_valid=0; coef_last=0; coef_idx=0; coef_out=0; overflow=0.
  - State FILL, vector counter 0, drain counter 0.
  - Coefficient store contents are not reset.
- Vector capture: at an edge with valid_in && in_ready, write in_vec to store row v = vector counter, then increment the counter.
- FSM, single-bank (default build):
  - FILL: in_ready=1, coef_valid=0. At the edge capturing vector DIM-1, the vector counter wraps to 0 and the state becomes DRAIN.
  - DRAIN: in_ready=0, coef_valid=1.
    - coef_out = C[r][c], where (r,c) = zigzag(k) and k = drain counter; coef_idx=k; coef_last = (k==DIM*DIM-1).
    - At an edge with coef_ready, k increments. At k==DIM*DIM-1 with coef_ready, k returns to 0 and the state returns to FILL.
- Zigzag order, row-major index r*DIM+c, DIM=8: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ending 47,55,62,63.
- Latency: the first coefficient is valid in the cycle immediately after the edge that captured vector DIM-1.
  - Throughput is one coefficient per cycle while coef_ready=1.
  - Block turnaround (single bank) is DIM capture cycles plus DIM*DIM drain cycles minimum.
- Handshake:
  - coef_out, coef_idx and coef_last hold stable while coef_valid=1 and coef_ready=0.
  - coef_valid never drops without a transfer.
- Dropped input: valid_in while in_ready=0 leaves the store and counters unchanged and sets overflow=1 at that edge. overflow clears only on reset.
- coef_ready while coef_valid=0 is ignored.
- Reset mid-operation (FILL or DRAIN): the partial block is discarded and all outputs return to reset values on the next cycle.
- Arithmetic: coefficients are passed through unmodified; no clipping or rounding.

Optional Feature:
- Macro: DCT_ZZ_PINGPONG_EN.
- Defined:
  - The store has two banks. Fill bank and drain bank are tracked independently: each bank is EMPTY, FILLING or FULL.
  - in_ready=1 unless both banks are FULL or one bank is FULL/draining while the other is FULL.
  - Vectors fill the non-draining bank while the other drains. When a fill completes, that bank becomes FULL and is drained next, in block arrival order.
  - Capture of vector DIM-1 and the final drain transfer of the other bank may occur on the same edge. Both take effect, and the newly full bank starts draining the following cycle with no bubble.
  - Sustained throughput is one block per DIM*DIM cycles.
- Undefined: single-bank behaviour exactly as specified above; no bank-select logic is present.

Test Plan:
- Reset, then capture 8 vectors with C[v][e]=v*8+e and coef_ready=1 -> coef_valid rises the cycle after the 8th capture. Stream is 0,1,8,16,9,2,3,10,17,24,... with coef_idx 0..63. coef_last=1 only with value 63. in_ready=0 during drain and returns to 1 after.
- Same block with coef_ready toggling 1,0,0,1,... -> no value skipped or repeated; outputs stable during each stall; 64 transfers total.
- Single bank, valid_in held high during DRAIN for 3 cycles -> overflow=1 and sticky. Drained block unchanged. Next block is captured correctly after return to FILL.
- Assert rst=0 for 1 cycle after 30 drained coefficients -> next cycle coef_valid=0, in_ready=1, overflow=0. A fresh block with C[v][e]=-(v*8+e) drains as 0,-1,-8,-16,...,-63.
- DCT_ZZ_PINGPONG_EN defined, two back-to-back blocks (values v*8+e, then 100+v*8+e), coef_ready=1 -> 128 consecutive valid cycles with no gap and no overflow. Second block starts with 100 right after 63.
- DCT_ZZ_PINGPONG_EN defined, coef_ready=0 while 3 blocks are offered -> in_ready drops after 2 blocks are full and the third block's vectors set overflow. Releasing coef_ready drains block 1, then block 2.

Source files
------------

// File: rtl/dct_zigzag_serializer.sv
// Collects DIM result vectors of one DCT block and streams the coefficients in zigzag order.
// Define DCT_ZZ_PINGPONG_EN for a two-bank store that fills one block while the other drains.
module dct_zigzag_serializer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIM       = 8,
  parameter int unsigned IDX_WIDTH = $clog2(DIM*DIM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DIM*WIDTH-1:0]    in_vec,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] coef_out,
  output logic [IDX_WIDTH-1:0]    coef_idx,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic                    coef_last,
  output logic                    overflow
);

  localparam int unsigned NCOEF = DIM*DIM;
  localparam int          DIM_I = int'(DIM);
  localparam int unsigned VEC_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [VEC_W-1:0]     LAST_VEC = VEC_W'(DIM-1);
  localparam logic [IDX_WIDTH-1:0] LAST_K   = IDX_WIDTH'(NCOEF-1);

  // Zigzag table: entry k holds the row-major position r*DIM+c of zigzag index k.
  function automatic logic [NCOEF*IDX_WIDTH-1:0] build_zz();
    logic [NCOEF*IDX_WIDTH-1:0] tab;
    int n;
    int lo;
    int hi;
    int r;
    tab = '0;
    n   = 0;
    for (int s = 0; s < 2*DIM_I-1; s++) begin
      lo = (s > DIM_I-1) ? s-(DIM_I-1) : 0;
      hi = (s < DIM_I) ? s : DIM_I-1;
      for (int j = 0; j < DIM_I; j++) begin
        if (j <= hi-lo) begin
          r = (s % 2 == 1) ? lo+j : hi-j;
          tab[n*IDX_WIDTH +: IDX_WIDTH] = IDX_WIDTH'(r*DIM_I + (s-r));
          n++;
        end
      end
    end
    return tab;
  endfunction

  localparam logic [NCOEF*IDX_WIDTH-1:0] ZZ_TAB = build_zz();

  logic [VEC_W-1:0]     vcnt_q, vcnt_d;
  logic [IDX_WIDTH-1:0] k_q, k_d;
  logic                 capture, xfer, vec_last, drain_last;
  logic                 in_ready_d, coef_valid_d;
  logic [IDX_WIDTH-1:0] rd_pos;
  logic signed [WIDTH-1:0] rd_data;

  assign capture    = valid_in & in_ready;
  assign xfer       = coef_valid & coef_ready;
  assign vec_last   = capture && (vcnt_q == LAST_VEC);
  assign drain_last = xfer && (k_q == LAST_K);

`ifdef DCT_ZZ_PINGPONG_EN

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_t;

  bank_t bank_q [2];
  bank_t bank_d [2];
  logic  fill_sel_q, fill_sel_d;
  logic  drain_sel_q, drain_sel_d;
  logic signed [WIDTH-1:0] store [2][NCOEF];

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
    end
  end

  // Drain release and fill completion can hit different banks on the same edge.
  always_comb begin
    bank_d      = bank_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    if (drain_last) begin
      bank_d[drain_sel_q] = EMPTY;
      drain_sel_d         = ~drain_sel_q;
    end
    if (capture) begin
      bank_d[fill_sel_q] = vec_last ? FULL : FILLING;
      if (vec_last) begin
        fill_sel_d = ~fill_sel_q;
      end
    end
    in_ready_d   = (bank_d[fill_sel_d] != FULL);
    coef_valid_d = (bank_d[drain_sel_d] == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst && capture) begin
      for (int e = 0; e < DIM_I; e++) begin
        store[fill_sel_q][IDX_WIDTH'(32'(vcnt_q)*DIM + 32'(e))] <= in_vec[e*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_data = store[drain_sel_d][rd_pos];

`else

  typedef enum logic {FILL, DRAIN} state_t;

  state_t state_q, state_d;
  logic signed [WIDTH-1:0] store [NCOEF];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (vec_last)   state_d = DRAIN;
      DRAIN:   if (drain_last) state_d = FILL;
      default: state_d = FILL;
    endcase
    in_ready_d   = (state_d == FILL);
    coef_valid_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst && capture) begin
      for (int e = 0; e < DIM_I; e++) begin
        store[IDX_WIDTH'(32'(vcnt_q)*DIM + 32'(e))] <= in_vec[e*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_data = store[rd_pos];

`endif

  // Counters and the look-ahead read address; zigzag(0) is row 0, never the row written
  // on the completing edge, so no write-to-read bypass is needed for DIM > 1.
  always_comb begin
    vcnt_d = vcnt_q;
    k_d    = k_q;
    if (capture) begin
      vcnt_d = vec_last ? '0 : vcnt_q + VEC_W'(1);
    end
    if (xfer) begin
      k_d = drain_last ? '0 : k_q + IDX_WIDTH'(1);
    end
    rd_pos = ZZ_TAB[32'(k_d)*IDX_WIDTH +: IDX_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vcnt_q     <= '0;
      k_q        <= '0;
      in_ready   <= 1'b1;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
      coef_idx   <= '0;
      coef_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      vcnt_q     <= vcnt_d;
      k_q        <= k_d;
      in_ready   <= in_ready_d;
      coef_valid <= coef_valid_d;
      coef_last  <= coef_valid_d && (k_d == LAST_K);
      coef_idx   <= coef_valid_d ? k_d : '0;
      coef_out   <= coef_valid_d ? rd_data : '0;
      overflow   <= overflow | (valid_in & ~in_ready);
    end
  end

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
// Self-checking bench for dct_zigzag_serializer against a rank-based zigzag reference model.
module tb_dct_zigzag_serializer;

  localparam int WIDTH = 16;
  localparam int DIM   = 8;
  localparam int N     = DIM*DIM;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in;
  logic [DIM*WIDTH-1:0]    in_vec;
  logic                    in_ready;
  logic signed [WIDTH-1:0] coef_out;
  logic [5:0]              coef_idx;
  logic                    coef_valid;
  logic                    coef_ready;
  logic                    coef_last;
  logic                    overflow;

  always #5 clk = ~clk;

  dct_zigzag_serializer #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .in_vec     (in_vec),
    .in_ready   (in_ready),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;
  int blk [4][N];
  int zz_ref [N];
  int spec_head [16] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5};
  bit ident;
  int first_valid;
  int last_xfer;
  int saw_busy;
  int popped;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zigzag by ranking every cell on (anti-diagonal, position along the walk direction).
  function automatic void build_zz();
    int key [N];
    int r, c, s, rk;
    for (int p = 0; p < N; p++) begin
      r = p / DIM;
      c = p % DIM;
      s = r + c;
      key[p] = s*DIM + ((s % 2 == 1) ? r : c);
    end
    for (int p = 0; p < N; p++) begin
      rk = 0;
      for (int q = 0; q < N; q++) if (key[q] < key[p]) rk++;
      zz_ref[rk] = p;
    end
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'(1));
    chk({tag, "_coef_valid"}, 32'(coef_valid), 32'(0));
    chk({tag, "_coef_last"},  32'(coef_last),  32'(0));
    chk({tag, "_coef_idx"},   32'(coef_idx),   32'(0));
    chk({tag, "_coef_out"},   32'(coef_out),   32'(0));
    chk({tag, "_overflow"},   32'(overflow),   32'(0));
  endtask

  // Feeds nblk blocks whenever in_ready, drains with the chosen ready pattern and checks
  // each coefficient against the model; ovf_hold extra vectors are pushed while in_ready=0.
  task automatic run(input int b0, input int nblk, input int rmode, input int ovf_hold,
                     input int max_pop, input int budget);
    int  exp_q [$];
    int  sent;
    int  t;
    int  ovf_left;
    int  lat_cyc;
    int  vb, vv;
    bit  r;
    bit  pv, pr;
    sent = 0; t = 0; ovf_left = ovf_hold; lat_cyc = -1; pv = 1'b0; pr = 1'b0;
    first_valid = -1; last_xfer = -1; saw_busy = 0; popped = 0;
    for (int b = 0; b < nblk; b++)
      for (int n = 0; n < N; n++) exp_q.push_back(blk[b0+b][zz_ref[n]]);
    while ((exp_q.size() > 0 || sent < nblk*DIM) && popped < max_pop && t < budget) begin
      if (pv && !pr) chk("valid_held_in_stall", 32'(coef_valid), 32'(1));
      if (!in_ready) saw_busy = 1;
      if (coef_valid) begin
        if (first_valid < 0) begin
          first_valid = t;
          if (lat_cyc >= 0) chk("first_coef_latency", 32'(t), 32'(lat_cyc + 1));
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(coef_valid), 32'(0));
        end else begin
          chk("coef_out",  32'(coef_out),  32'(exp_q[0]));
          chk("coef_idx",  32'(coef_idx),  32'(popped % N));
          chk("coef_last", 32'(coef_last), 32'((popped % N) == N-1));
          if (ident && popped < 16) chk("zz_head", 32'(coef_out), 32'(spec_head[popped]));
        end
`ifndef DCT_ZZ_PINGPONG_EN
        chk("in_ready_in_drain", 32'(in_ready), 32'(0));
`endif
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (t % 3 == 0);
        2:       r = 1'($urandom_range(0, 1));
        default: r = (t >= 40);
      endcase
      if (coef_valid && r && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        popped++;
        last_xfer = t;
      end
      coef_ready = r;
      if (sent < nblk*DIM && in_ready) begin
        vb = b0 + sent / DIM;
        vv = sent % DIM;
        valid_in = 1'b1;
        for (int e = 0; e < DIM; e++) in_vec[e*WIDTH +: WIDTH] = 16'(blk[vb][vv*DIM + e]);
        if (vv == DIM-1 && lat_cyc < 0) lat_cyc = t;
        sent++;
      end else if (ovf_left > 0 && !in_ready) begin
        valid_in = 1'b1;
        in_vec   = {$urandom, $urandom, $urandom, $urandom};
        ovf_left--;
      end else begin
        valid_in = 1'b0;
      end
      pv = coef_valid;
      pr = r;
      step();
      t++;
    end
    valid_in = 1'b0;
    chk("run_within_budget", 32'(t < budget), 32'(1));
  endtask

  initial begin
    build_zz();
    for (int p = 0; p < N; p++) begin
      blk[0][p] = p;
      blk[1][p] = 100 + p;
      blk[2][p] = int'($urandom_range(0, 65535)) - 32768;
      blk[3][p] = -p;
    end
    rst = 1'b0; valid_in = 1'b0; in_vec = '0; coef_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    check_reset_state("reset");

    // Identity block, continuous ready.
    ident = 1'b1;
    run(0, 1, 0, 0, N, 400);
    ident = 1'b0;
    chk("ready_after_block", 32'(in_ready), 32'(1));
    chk("idle_after_block", 32'(coef_valid), 32'(0));
    chk("busy_seen", 32'(saw_busy), 32'(1));

    // Same block under a 1,0,0 ready pattern.
    run(0, 1, 1, 0, N, 600);
    chk("stall_transfers", 32'(popped), 32'(N));
    chk("ready_after_stall", 32'(in_ready), 32'(1));

    // Random values and random ready.
    run(2, 1, 2, 0, N, 600);
    chk("no_overflow_yet", 32'(overflow), 32'(0));

`ifndef DCT_ZZ_PINGPONG_EN
    // Vectors offered during drain are dropped and flagged.
    run(2, 1, 0, 3, N, 400);
    chk("overflow_set", 32'(overflow), 32'(1));
    run(1, 1, 2, 0, N, 600);
    chk("overflow_sticky", 32'(overflow), 32'(1));
    chk("ready_after_ovf", 32'(in_ready), 32'(1));
`else
    // Back-to-back blocks drain with no gap.
    run(0, 2, 0, 0, 2*N, 600);
    chk("pp_no_gap", 32'(last_xfer - first_valid + 1), 32'(2*N));
    chk("pp_no_overflow", 32'(overflow), 32'(0));
    // Two full banks stall input; third block's vectors are dropped.
    run(0, 2, 3, 8, 2*N, 800);
    chk("pp_busy_seen", 32'(saw_busy), 32'(1));
    chk("pp_overflow", 32'(overflow), 32'(1));
    chk("pp_ready_after", 32'(in_ready), 32'(1));
`endif

    // Reset in the middle of a drain.
    coef_ready = 1'b1;
    run(2, 1, 0, 0, 30, 400);
    chk("idx_before_reset", 32'(coef_idx), 32'(30));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_state("mid_reset");
    run(3, 1, 2, 0, N, 600);
    chk("neg_block_done", 32'(popped), 32'(N));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
